// File: rtl/axi_led_pattern_ctrl.sv
// AXI4-Lite LED controller: CTRL/PATTERN/PERIOD/STATUS registers driving a
// parametrised LED bank in static, even-mask, blink or chase mode.
module axi_led_pattern_ctrl #(
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ADDR_WIDTH = 4,
  parameter int          NUM_LEDS           = 8,
  parameter logic [31:0] DEFAULT_PERIOD     = 32'd50_000_000
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [NUM_LEDS-1:0]             leds
);

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_PATTERN = 2'd1;
  localparam logic [1:0] REG_PERIOD  = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_EVEN   = 2'd1;
  localparam logic [1:0] MODE_BLINK  = 2'd2;
  localparam logic [1:0] MODE_CHASE  = 2'd3;

  function automatic logic [NUM_LEDS-1:0] even_mask_f();
    logic [NUM_LEDS-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_LEDS; i += 2) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [NUM_LEDS-1:0] EVEN_MASK = even_mask_f();

  // Handshake rules: a channel transfers on a rising edge where valid and
  // ready are both high; the slave holds bvalid/rvalid (and rdata) until the
  // master's ready, and refuses a new request while its response is pending.
  logic                            r_awready;
  logic                            r_wready;
  logic                            r_bvalid;
  logic                            r_arready;
  logic                            r_rvalid;
  logic [C_S_AXI_DATA_WIDTH-1:0]   r_rdata;
  logic [1:0]                      r_araddr;

  logic [2:0]          r_ctrl;
  logic [NUM_LEDS-1:0] r_pattern;
  logic [31:0]         r_period;
  logic [31:0]         r_cnt;
  logic                r_phase;
  logic [NUM_LEDS-1:0] r_chase;
  logic [NUM_LEDS-1:0] r_leds;

  logic                w_wr_accept;
  logic                w_rd_accept;
  logic [1:0]          w_wr_sel;
  logic [31:0]         w_strb_mask;
  logic [31:0]         w_ctrl_view;
  logic [31:0]         w_pattern_view;
  logic [31:0]         w_status_view;
  logic [31:0]         w_wr_old;
  logic [31:0]         w_wr_new;
  logic [31:0]         w_rd_val;
  logic                w_wr_ctrl;
  logic                w_wr_pattern;
  logic                w_wr_period;
  logic                w_mode_written;
  logic                w_chase_load_ctrl;
  logic                w_enable;
  logic [1:0]          w_mode;
  logic [31:0]         w_period_eff;
  logic                w_tick;
  logic [NUM_LEDS-1:0] w_chase_rot;
  logic [NUM_LEDS-1:0] w_leds_next;
  logic                w_unused_ok;

  assign w_wr_accept = s00_axi_awvalid & s00_axi_wvalid & ~r_awready & ~r_bvalid;
  assign w_rd_accept = s00_axi_arvalid & ~r_arready & ~r_rvalid;
  assign w_wr_sel    = s00_axi_awaddr[3:2];

  assign w_enable = r_ctrl[2];
  assign w_mode   = r_ctrl[1:0];

  always_comb begin
    w_strb_mask = '0;
    for (int i = 0; i < 4; i++) w_strb_mask[8*i +: 8] = {8{s00_axi_wstrb[i]}};
  end

  always_comb begin
    w_ctrl_view              = '0;
    w_ctrl_view[2:0]         = r_ctrl;
    w_pattern_view           = '0;
    w_pattern_view[NUM_LEDS-1:0] = r_pattern;
    w_status_view            = '0;
    w_status_view[NUM_LEDS-1:0]  = r_leds;
    w_status_view[16]        = r_phase;
  end

  // Byte-lane merge against the current register contents, so a partial
  // strobe leaves untouched lanes as they were.
  always_comb begin
    w_wr_old = '0;
    case (w_wr_sel)
      REG_CTRL:    w_wr_old = w_ctrl_view;
      REG_PATTERN: w_wr_old = w_pattern_view;
      REG_PERIOD:  w_wr_old = r_period;
      default:     w_wr_old = w_status_view;
    endcase
  end

  assign w_wr_new = (w_wr_old & ~w_strb_mask) | (s00_axi_wdata & w_strb_mask);

  always_comb begin
    w_rd_val = '0;
    case (r_araddr)
      REG_CTRL:    w_rd_val = w_ctrl_view;
      REG_PATTERN: w_rd_val = w_pattern_view;
      REG_PERIOD:  w_rd_val = r_period;
      default:     w_rd_val = w_status_view;
    endcase
  end

  assign w_wr_ctrl         = w_wr_accept && (w_wr_sel == REG_CTRL);
  assign w_wr_pattern      = w_wr_accept && (w_wr_sel == REG_PATTERN);
  assign w_wr_period       = w_wr_accept && (w_wr_sel == REG_PERIOD);
  assign w_mode_written    = w_wr_ctrl && s00_axi_wstrb[0];
  assign w_chase_load_ctrl = w_mode_written && (w_wr_new[1:0] == MODE_CHASE);

  // PERIOD of zero is treated as one so the prescaler never stalls.
  assign w_period_eff = (r_period == 32'd0) ? 32'd1 : r_period;
  assign w_tick       = w_enable && (r_cnt == (w_period_eff - 32'd1));

  // Written as OR of two shifts so a 1-LED build degenerates to identity.
  assign w_chase_rot = (r_chase << 1) | (r_chase >> (NUM_LEDS - 1));

  always_comb begin
    w_leds_next = '0;
    if (w_enable) begin
      case (w_mode)
        MODE_STATIC: w_leds_next = r_pattern;
        MODE_EVEN:   w_leds_next = r_pattern & EVEN_MASK;
        MODE_BLINK:  w_leds_next = r_phase ? r_pattern : '0;
        default:     w_leds_next = r_chase;
      endcase
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
    end else begin
      r_awready <= w_wr_accept;
      r_wready  <= w_wr_accept;
      if (r_awready) r_bvalid <= 1'b1;
      else if (r_bvalid && s00_axi_bready) r_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_araddr  <= 2'd0;
    end else begin
      r_arready <= w_rd_accept;
      if (w_rd_accept) r_araddr <= s00_axi_araddr[3:2];
      if (r_arready) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_val;
      end else if (r_rvalid && s00_axi_rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_ctrl    <= 3'd0;
      r_pattern <= '0;
      r_period  <= DEFAULT_PERIOD;
    end else begin
      if (w_wr_ctrl)    r_ctrl    <= w_wr_new[2:0];
      if (w_wr_pattern) r_pattern <= w_wr_new[NUM_LEDS-1:0];
      if (w_wr_period)  r_period  <= w_wr_new;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_aresetn) begin
      r_cnt   <= 32'd0;
      r_phase <= 1'b0;
      r_chase <= '0;
      r_leds  <= '0;
    end else begin
      if (!w_enable || w_wr_period || w_tick) r_cnt <= 32'd0;
      else r_cnt <= r_cnt + 32'd1;

      if (!w_enable || w_mode_written) r_phase <= 1'b0;
      else if (w_tick) r_phase <= ~r_phase;

      // A load in the same cycle as a chase tick takes priority over the rotate.
      if (w_wr_pattern) r_chase <= w_wr_new[NUM_LEDS-1:0];
      else if (w_chase_load_ctrl) r_chase <= r_pattern;
      else if (w_tick && (w_mode == MODE_CHASE)) r_chase <= w_chase_rot;

      r_leds <= w_leds_next;
    end
  end

  assign w_unused_ok = ^{s00_axi_awaddr, s00_axi_araddr, s00_axi_awprot, s00_axi_arprot};

  assign s00_axi_awready = r_awready;
  assign s00_axi_wready  = r_wready;
  assign s00_axi_bvalid  = r_bvalid;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_arready = r_arready;
  assign s00_axi_rvalid  = r_rvalid;
  assign s00_axi_rdata   = r_rdata;
  assign s00_axi_rresp   = 2'b00;
  assign leds            = r_leds;

endmodule

// File: tb/tb_axi_led_pattern_ctrl.sv
// Directed bench for axi_led_pattern_ctrl: a register-level vector table plus
// hand-written chase, blink, load-vs-rotate and backpressure/reset sequences.
module tb_axi_led_pattern_ctrl;

  localparam int NL = 8;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [3:0]  awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [NL-1:0] leds;

  always #5 clk = ~clk;

  axi_led_pattern_ctrl #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .NUM_LEDS(NL),
    .DEFAULT_PERIOD(32'd50_000_000)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(aresetn),
    .s00_axi_awaddr(awaddr),
    .s00_axi_awprot(awprot),
    .s00_axi_awvalid(awvalid),
    .s00_axi_awready(awready),
    .s00_axi_wdata(wdata),
    .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid),
    .s00_axi_wready(wready),
    .s00_axi_bresp(bresp),
    .s00_axi_bvalid(bvalid),
    .s00_axi_bready(bready),
    .s00_axi_araddr(araddr),
    .s00_axi_arprot(arprot),
    .s00_axi_arvalid(arvalid),
    .s00_axi_arready(arready),
    .s00_axi_rdata(rdata),
    .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid),
    .s00_axi_rready(rready),
    .leds(leds)
  );

  typedef struct {
    logic          is_wr;
    logic [3:0]    addr;
    logic [31:0]   data;
    logic [3:0]    strb;
    logic          chk_leds;
    logic [NL-1:0] exp_leds;
  } vec_t;

  vec_t          vecs[21];
  logic [31:0]   exp_q[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [NL-1:0] leds_at_b;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
    int cyc;
    @(negedge clk);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!awready && cyc < 20);
    check("awready", 32'(awready), 32'd1);
    check("wready", 32'(wready), 32'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    leds_at_b = leds;
    check("bvalid", 32'(bvalid), 32'd1);
    check("bresp", 32'(bresp), 32'd0);
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
    int cyc;
    @(negedge clk);
    araddr = addr; arvalid = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (!arready && cyc < 20);
    check("arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("rvalid", 32'(rvalid), 32'd1);
    check("rresp", 32'(rresp), 32'd0);
    data = rdata;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic run_vectors(input int lo, input int hi);
    logic [31:0] got;
    for (int i = lo; i <= hi; i++) begin
      if (vecs[i].is_wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
      end else begin
        exp_q.push_back(vecs[i].data);
        axi_read(vecs[i].addr, got);
        check($sformatf("vec%0d_rdata", i), got, exp_q.pop_front());
      end
      if (vecs[i].chk_leds) check($sformatf("vec%0d_leds", i), 32'(leds), 32'(vecs[i].exp_leds));
    end
  endtask

  task automatic wait_change(input logic [NL-1:0] prev, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1; cyc++;
    end while (leds == prev && cyc < 12);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]   got;
    logic [NL-1:0] prev;
    logic [NL-1:0] chase_exp[8];
    int            cyc;

    //          wr    addr   data            strb   chk   leds
    vecs[0]  = '{1'b0, 4'h0, 32'h0000_0000, 4'h0, 1'b1, 8'h00};
    vecs[1]  = '{1'b0, 4'h4, 32'h0000_0000, 4'h0, 1'b0, 8'h00};
    vecs[2]  = '{1'b0, 4'h8, 32'h02FA_F080, 4'h0, 1'b0, 8'h00};
    vecs[3]  = '{1'b0, 4'hC, 32'h0000_0000, 4'h0, 1'b1, 8'h00};
    vecs[4]  = '{1'b1, 4'h4, 32'h0000_00FF, 4'hF, 1'b1, 8'h00};
    vecs[5]  = '{1'b1, 4'h0, 32'h0000_0005, 4'hF, 1'b1, 8'h55};
    vecs[6]  = '{1'b0, 4'hC, 32'h0000_0055, 4'h0, 1'b1, 8'h55};
    vecs[7]  = '{1'b0, 4'h0, 32'h0000_0005, 4'h0, 1'b0, 8'h00};
    vecs[8]  = '{1'b1, 4'h0, 32'h0000_0004, 4'hF, 1'b1, 8'hFF};
    vecs[9]  = '{1'b0, 4'hC, 32'h0000_00FF, 4'h0, 1'b0, 8'h00};
    vecs[10] = '{1'b1, 4'h4, 32'hAABB_CCDD, 4'h1, 1'b1, 8'h00};
    vecs[11] = '{1'b0, 4'h4, 32'h0000_00DD, 4'h0, 1'b0, 8'h00};
    vecs[12] = '{1'b1, 4'h8, 32'h1122_3344, 4'h6, 1'b0, 8'h00};
    vecs[13] = '{1'b0, 4'h8, 32'h0022_3300, 4'h0, 1'b0, 8'h00};
    vecs[14] = '{1'b1, 4'hC, 32'h0000_1234, 4'hF, 1'b1, 8'h00};
    vecs[15] = '{1'b0, 4'hC, 32'h0000_0000, 4'h0, 1'b0, 8'h00};
    vecs[16] = '{1'b0, 4'h4, 32'h0000_00DD, 4'h0, 1'b0, 8'h00};
    vecs[17] = '{1'b1, 4'h1, 32'h0000_0007, 4'hF, 1'b1, 8'hDD};
    vecs[18] = '{1'b0, 4'h3, 32'h0000_0007, 4'h0, 1'b0, 8'h00};
    vecs[19] = '{1'b1, 4'h0, 32'hFFFF_FFF9, 4'hF, 1'b1, 8'h00};
    vecs[20] = '{1'b0, 4'h0, 32'h0000_0001, 4'h0, 1'b0, 8'h00};

    chase_exp = '{8'h03, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81};

    // clock / reset
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_handshake", 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_leds", 32'(leds), 32'd0);
    @(negedge clk);
    aresetn = 1'b1;

    // reset read-back, even mode, static mode
    run_vectors(0, 9);

    // chase: one step every 4 clocks, wrapping after 8 ticks
    axi_write(4'h8, 32'd4, 4'hF);
    axi_write(4'h4, 32'h81, 4'hF);
    axi_write(4'h0, 32'h7, 4'hF);
    check("chase_start", 32'(leds), 32'h81);
    prev = leds;
    for (int s = 0; s < 8; s++) begin
      wait_change(prev, cyc);
      check($sformatf("chase_step%0d", s), 32'(leds), 32'(chase_exp[s]));
      if (s > 0) check($sformatf("chase_interval%0d", s), 32'(cyc), 32'd4);
      prev = leds;
    end

    // blink with PERIOD=0: toggles every cycle
    axi_write(4'h8, 32'd0, 4'hF);
    axi_write(4'h4, 32'h0F, 4'hF);
    axi_write(4'h0, 32'h6, 4'hF);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("blink%0d", i), 32'(leds), (i % 2 == 0) ? 32'h0F : 32'h00);
      @(posedge clk); #1;
    end
    axi_write(4'h0, 32'h2, 4'hF);
    check("blink_off_leds", 32'(leds), 32'd0);
    axi_read(4'hC, got);
    check("blink_off_status", got, 32'd0);

    // strobes, STATUS write ignored, addr[1:0] ignored, CTRL upper bits
    run_vectors(10, 20);

    // PATTERN write on a chase tick: load beats rotate
    axi_write(4'h8, 32'd0, 4'hF);
    axi_write(4'h0, 32'h7, 4'hF);
    axi_write(4'h4, 32'h5A, 4'hF);
    check("load_wins", 32'(leds_at_b), 32'h5A);
    check("rotate_after_load", 32'(leds), 32'hB4);

    // backpressure with simultaneous write/read of PERIOD, then reset mid-wait
    @(negedge clk);
    awaddr = 4'h8; wdata = 32'h0000_1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 4'h8; arvalid = 1'b1;
    bready = 1'b0; rready = 1'b0;
    @(posedge clk); #1;
    check("bp_accept", 32'({awready, wready, arready}), 32'h7);
    @(posedge clk); #1;
    check("bp_rdata_new", rdata, 32'h0000_1234);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold%0d", i), 32'({bvalid, rvalid, awready, arready}), 32'hC);
      @(posedge clk); #1;
    end
    @(negedge clk);
    aresetn = 1'b0;
    @(posedge clk); #1;
    check("bp_rst_handshake", 32'({awready, wready, bvalid, arready, rvalid}), 32'd0);
    check("bp_rst_leds", 32'(leds), 32'd0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk); #1;
    check("bp_no_resp", 32'({bvalid, rvalid}), 32'd0);
    axi_read(4'h0, got);
    check("post_rst_ctrl", got, 32'd0);
    axi_read(4'h4, got);
    check("post_rst_pattern", got, 32'd0);
    axi_read(4'h8, got);
    check("post_rst_period", got, 32'h02FA_F080);
    axi_read(4'hC, got);
    check("post_rst_status", got, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
